// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Requester-side and physical-memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_read;
    logic [ADDR_W-1:0]     i_address;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [DATA_W/8-1:0]   d_byte_enable;
    logic [ADDR_W-1:0]     d_address;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [DATA_W/8-1:0]   pmem_byte_enable;
    logic [ADDR_W-1:0]     pmem_address;
    logic [DATA_W-1:0]     pmem_wdata;
    logic [DATA_W-1:0]     pmem_rdata;
    logic                  pmem_resp;

    logic                  busy;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output busy
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin arbiter serialising fetch and load/store requests onto one memory port
module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_I  = 2'd1,
        SERVE_DR = 2'd2,
        SERVE_DW = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state_q, state_d;
    grant_t last_grant_q, last_grant_d;
    logic   i_req;
    logic   d_req;
    logic   pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Data wins when it is the only requester or when instruction had the previous grant.
    always_comb begin
        i_req        = bus.i_read;
        d_req        = bus.d_read | bus.d_write;
        pick_d       = d_req & (~i_req | (last_grant_q == GRANT_I));
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = bus.d_write ? SERVE_DW : SERVE_DR;
                    last_grant_d = GRANT_D;
                end else if (i_req) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                end
            end
            default: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Memory command depends only on the state and the held requester inputs, never on pmem_resp.
    always_comb begin
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.pmem_byte_enable = '0;
        bus.pmem_address     = '0;
        bus.pmem_wdata       = '0;
        case (state_q)
            SERVE_I: begin
                bus.pmem_read        = 1'b1;
                bus.pmem_address     = bus.i_address;
                bus.pmem_byte_enable = '1;
            end
            SERVE_DR: begin
                bus.pmem_read        = 1'b1;
                bus.pmem_address     = bus.d_address;
                bus.pmem_byte_enable = '1;
            end
            SERVE_DW: begin
                bus.pmem_write       = 1'b1;
                bus.pmem_address     = bus.d_address;
                bus.pmem_wdata       = bus.d_wdata;
                bus.pmem_byte_enable = bus.d_byte_enable;
            end
            default: ;
        endcase
    end

    assign bus.i_resp  = (state_q == SERVE_I) & bus.pmem_resp;
    assign bus.d_resp  = ((state_q == SERVE_DR) | (state_q == SERVE_DW)) & bus.pmem_resp;
    assign bus.busy    = (state_q != IDLE);
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none 1=fetch 2=data read 3=data write; last 1=fetch 2=data
    int m_owner = 0;
    int m_last  = 2;
    int m_cnt   = 0;
    int force_lat = -1;
    bit stray_en = 1'b0;
    bit stray_once = 1'b0;
    bit rd_fixed = 1'b0;
    logic [31:0] rd_val = '0;
    int served[$];
    int gaps[$];
    int cyc = 0;
    int last_resp_cyc = 0;
    bit have_resp = 1'b0;
    bit prev_cmd = 1'b0;

    logic s_iresp, s_dresp;
    logic [31:0] s_irdata, s_drdata;
    int cmd_cycles;
    bit got_cmd;
    logic c_rd, c_wr;
    logic [3:0] c_be;
    logic [31:0] c_addr, c_wdata;
    int i_wait, d_wait, i_max, d_max;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        int          exp_cycles;
        logic        exp_i;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic er, ew;
        logic [31:0] ea, ewd;
        logic [3:0] ebe;
        logic cmd;
        er = 1'b0; ew = 1'b0; ea = '0; ewd = '0; ebe = '0;
        case (m_owner)
            1: begin er = 1'b1; ea = bus.i_address; ebe = 4'hF; end
            2: begin er = 1'b1; ea = bus.d_address; ebe = 4'hF; end
            3: begin ew = 1'b1; ea = bus.d_address; ewd = bus.d_wdata; ebe = bus.d_byte_enable; end
            default: ;
        endcase
        chk("busy", bus.busy, m_owner != 0);
        chk("pmem_read", bus.pmem_read, er);
        chk("pmem_write", bus.pmem_write, ew);
        chk("pmem_address", bus.pmem_address, ea);
        chk("pmem_byte_enable", bus.pmem_byte_enable, ebe);
        if (m_owner == 0 || m_owner == 3) chk("pmem_wdata", bus.pmem_wdata, ewd);
        chk("i_resp", bus.i_resp, (m_owner == 1) && bus.pmem_resp);
        chk("d_resp", bus.d_resp, (m_owner >= 2) && bus.pmem_resp);
        chk("i_rdata", bus.i_rdata, bus.pmem_rdata);
        chk("d_rdata", bus.d_rdata, bus.pmem_rdata);
        s_iresp = bus.i_resp; s_dresp = bus.d_resp;
        s_irdata = bus.i_rdata; s_drdata = bus.d_rdata;
        cmd = bus.pmem_read | bus.pmem_write;
        if (cmd) begin
            cmd_cycles++;
            if (!got_cmd) begin
                got_cmd = 1'b1;
                c_rd = bus.pmem_read; c_wr = bus.pmem_write; c_be = bus.pmem_byte_enable;
                c_addr = bus.pmem_address; c_wdata = bus.pmem_wdata;
            end
        end
        if (cmd && !prev_cmd && have_resp) gaps.push_back(cyc - last_resp_cyc - 1);
        if (bus.i_resp || bus.d_resp) begin last_resp_cyc = cyc; have_resp = 1'b1; end
        prev_cmd = cmd;
    endtask

    // One clock: memory reply, check, then advance the model across the edge.
    task automatic cycle();
        logic ir, dr;
        if (m_owner != 0 && m_cnt == 0) bus.pmem_resp = 1'b1;
        else bus.pmem_resp = (m_owner == 0) && (stray_once || (stray_en && $urandom_range(0, 7) == 0));
        stray_once = 1'b0;
        bus.pmem_rdata = rd_fixed ? rd_val : $urandom;
        #2;
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (m_owner != 0) begin
            if (bus.pmem_resp) begin
                served.push_back(m_owner == 1 ? 1 : 2);
                m_owner = 0;
            end else begin
                m_cnt--;
            end
        end else begin
            ir = bus.i_read;
            dr = bus.d_read | bus.d_write;
            if (ir && (!dr || m_last == 2)) begin
                m_owner = 1; m_last = 1;
            end else if (dr) begin
                m_owner = bus.d_write ? 3 : 2; m_last = 2;
            end
            if (m_owner != 0) m_cnt = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        end
        bus.pmem_resp = 1'b0;
    endtask

    // mode 0: drop on resp only; 1: drop on resp then re-raise; 2: random requesters
    task automatic req_update(input int mode);
        int k;
        if (s_iresp) bus.i_read = 1'b0;
        else if (!bus.i_read && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))) begin
            bus.i_read = 1'b1;
            if (mode == 2) bus.i_address = $urandom & 32'hFFFF_FFFC;
        end
        if (s_dresp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
        else if (!(bus.d_read || bus.d_write) && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))) begin
            if (mode == 1) bus.d_read = 1'b1;
            else begin
                k = $urandom_range(0, 2);
                bus.d_read = (k != 1);
                bus.d_write = (k != 0);
                bus.d_address = $urandom & 32'hFFFF_FFFC;
                bus.d_wdata = $urandom;
                bus.d_byte_enable = 4'($urandom);
            end
        end
        if (bus.i_read) i_wait++; else i_wait = 0;
        if (bus.d_read || bus.d_write) d_wait++; else d_wait = 0;
        if (i_wait > i_max) i_max = i_wait;
        if (d_wait > d_max) d_max = d_wait;
    endtask

    task automatic clear_req();
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0;
        bus.d_wdata = '0; bus.d_byte_enable = '0;
    endtask

    task automatic run_until(input int n, input int mode);
        int budget;
        budget = 60 * n;
        while (served.size() < n && budget > 0) begin
            cycle();
            req_update(mode);
            budget--;
        end
        chk("served_count", served.size(), n);
    endtask

    task automatic mid_reset();
        bus.pmem_resp = 1'b0;
        rst = 1'b1;
        #1;
        m_owner = 0; m_last = 2; m_cnt = 0;
        clear_req();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h60,       32'h0,        4'h0, 2, 32'h0000_0013, 1'b1, 1'b0, 4'hF, 3, 1'b1};
        vecs[1] = '{1, 32'h200,      32'h0,        4'h5, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 4'hF, 1, 1'b0};
        vecs[2] = '{2, 32'h84,       32'hDEAD_BEEF, 4'h3, 1, 32'h1111_2222, 1'b0, 1'b1, 4'h3, 2, 1'b0};
        vecs[3] = '{3, 32'h84,       32'hDEAD_BEEF, 4'h3, 1, 32'h3333_4444, 1'b0, 1'b1, 4'h3, 2, 1'b0};
        vecs[4] = '{2, 32'h1000,     32'h1234_5678, 4'h8, 3, 32'h5555_6666, 1'b0, 1'b1, 4'h8, 4, 1'b0};
        vecs[5] = '{0, 32'hFFFF_FFFC, 32'h0,        4'h0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 1, 1'b1};

        clear_req();
        bus.d_write = 1'b1; bus.d_address = 32'h44; bus.d_wdata = 32'hA5A5_A5A5; bus.d_byte_enable = 4'hF;
        bus.pmem_resp = 1'b1; bus.pmem_rdata = '0;
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_pmem_write", bus.pmem_write, 0);
        chk("reset_pmem_address", bus.pmem_address, 0);
        chk("reset_pmem_wdata", bus.pmem_wdata, 0);
        chk("reset_pmem_be", bus.pmem_byte_enable, 0);
        chk("reset_d_resp", bus.d_resp, 0);
        chk("reset_i_resp", bus.i_resp, 0);
        clear_req();
        bus.pmem_resp = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            bit done;
            int ni, nd;
            logic [31:0] rdv;
            bus.i_read = (vecs[v].kind == 0);
            bus.i_address = (vecs[v].kind == 0) ? vecs[v].addr : 32'h0;
            bus.d_read = (vecs[v].kind == 1 || vecs[v].kind == 3);
            bus.d_write = (vecs[v].kind >= 2);
            bus.d_address = (vecs[v].kind != 0) ? vecs[v].addr : 32'h0;
            bus.d_wdata = vecs[v].wdata;
            bus.d_byte_enable = vecs[v].be;
            force_lat = vecs[v].lat;
            rd_fixed = 1'b1; rd_val = vecs[v].rdata;
            cmd_cycles = 0; got_cmd = 1'b0; done = 1'b0; ni = 0; nd = 0; rdv = '0;
            for (int c = 0; c < 20 && !done; c++) begin
                cycle();
                if (s_iresp) begin ni++; rdv = s_irdata; end
                if (s_dresp) begin nd++; rdv = s_drdata; end
                done = s_iresp | s_dresp;
                req_update(0);
            end
            cycle();
            chk("vec_done", done, 1);
            chk("vec_pmem_read", c_rd, vecs[v].exp_rd);
            chk("vec_pmem_write", c_wr, vecs[v].exp_wr);
            chk("vec_pmem_be", c_be, vecs[v].exp_be);
            chk("vec_pmem_address", c_addr, vecs[v].addr);
            if (vecs[v].exp_wr) chk("vec_pmem_wdata", c_wdata, vecs[v].wdata);
            chk("vec_cmd_cycles", cmd_cycles, vecs[v].exp_cycles);
            chk("vec_i_resp_count", ni, vecs[v].exp_i ? 1 : 0);
            chk("vec_d_resp_count", nd, vecs[v].exp_i ? 0 : 1);
            chk("vec_rdata", rdv, vecs[v].rdata);
        end
        rd_fixed = 1'b0;

        // Tie straight out of reset: fetch first, one idle gap, then data at 0x200
        mid_reset();
        served.delete(); gaps.delete(); have_resp = 1'b0;
        force_lat = 1;
        bus.i_read = 1'b1; bus.i_address = 32'h100;
        bus.d_read = 1'b1; bus.d_address = 32'h200;
        run_until(2, 0);
        if (served.size() >= 2) begin
            chk("tie_first_is_fetch", served[0], 1);
            chk("tie_second_is_data", served[1], 2);
        end
        chk("tie_gap_count", gaps.size(), 1);
        if (gaps.size() >= 1) chk("tie_gap_len", gaps[0], 1);
        cycle();

        // Continuous requests alternate I, D, I, D
        served.delete(); gaps.delete(); have_resp = 1'b0;
        force_lat = 2;
        bus.i_read = 1'b1; bus.i_address = 32'h400;
        bus.d_read = 1'b1; bus.d_address = 32'h800;
        run_until(4, 1);
        for (int k = 0; k < 4 && k < served.size(); k++) chk("rr_order", served[k], (k % 2 == 0) ? 1 : 2);
        foreach (gaps[k]) chk("rr_gap_len", gaps[k], 1);
        clear_req();
        run_until(4, 0);
        cycle();

        // After a lone fetch, the next tie goes to data
        served.delete();
        force_lat = 0;
        bus.i_read = 1'b1; bus.i_address = 32'h10;
        run_until(1, 0);
        cycle();
        bus.i_read = 1'b1; bus.i_address = 32'h14;
        bus.d_read = 1'b1; bus.d_address = 32'h24;
        run_until(3, 0);
        if (served.size() >= 3) begin
            chk("fair_after_fetch_data", served[1], 2);
            chk("fair_after_fetch_fetch", served[2], 1);
        end
        cycle();

        // Reset during a data read drops everything immediately
        force_lat = 5;
        bus.d_read = 1'b1; bus.d_address = 32'h300;
        cycle();
        cycle();
        chk("pre_reset_pmem_read", bus.pmem_read, 1);
        rst = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        chk("midrst_pmem_read", bus.pmem_read, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_d_resp", bus.d_resp, 0);
        mid_reset();
        served.delete();
        force_lat = 1;
        bus.i_read = 1'b1; bus.i_address = 32'h100;
        bus.d_read = 1'b1; bus.d_address = 32'h200;
        run_until(2, 0);
        if (served.size() >= 1) chk("post_reset_tie_fetch", served[0], 1);
        cycle();

        // Stray response while idle
        stray_once = 1'b1;
        cycle();
        chk("stray_i_resp", s_iresp, 0);
        chk("stray_d_resp", s_dresp, 0);
        cycle();
        chk("stray_still_idle", bus.busy, 0);

        // Randomised traffic against the model
        served.delete();
        force_lat = -1;
        stray_en = 1'b1;
        i_wait = 0; d_wait = 0; i_max = 0; d_max = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            req_update(2);
        end
        chk("rand_progress", served.size() > 200, 1);
        chk("rand_i_no_starve", i_max <= 16, 1);
        chk("rand_d_no_starve", d_max <= 16, 1);
        stray_en = 1'b0;
        clear_req();
        for (int c = 0; c < 10; c++) begin
            cycle();
            req_update(0);
        end
        chk("drain_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
